// File: rtl/bird_sprite_engine.sv
// bird_sprite_engine: bird physics plus erase-then-redraw pixel stream for the VGA adapter
module bird_sprite_engine #(
  parameter int X_POS = 24,
  parameter int Y_START = 48,
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int Y_MIN = 12,
  parameter int Y_MAX = 111,
  parameter int GRAV = 1,
  parameter int V_MAX = 6,
  parameter int FLAP_V = 6,
  parameter logic [2:0] BIRD_COL = 3'b110,
  parameter logic [2:0] BG_COL = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       tick,
  output logic [2:0] colour,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic       plot,
  output logic       busy,
  output logic       dead,
  output logic [7:0] y_pos
);
  localparam int N = SPR_W * SPR_H;
  localparam int PW = $clog2(N) + 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] WP = PW'(SPR_W);
  localparam logic [7:0] X0 = 8'(X_POS);
  localparam logic [7:0] Y0 = 8'(Y_START);
  localparam logic [7:0] YMIN8 = 8'(Y_MIN);
  localparam logic [7:0] YMAX8 = 8'(Y_MAX);
  localparam logic signed [9:0] G_S = 10'(GRAV);
  localparam logic signed [9:0] VM_S = 10'(V_MAX);
  localparam logic signed [9:0] FV_S = 10'(FLAP_V);
  localparam logic signed [9:0] YMIN_S = 10'(Y_MIN);
  localparam logic signed [9:0] YMAX_S = 10'(Y_MAX);

  typedef enum logic [2:0] {INIT_DRAW, READY, WAIT, ERASE, UPDATE, DRAW, DEAD, R_ERASE} state_t;
  state_t state, state_n;

  logic [PW-1:0] pix;
  logic [7:0] y;
  logic signed [9:0] vel, v_inc, v_nxt, y_nxt;
  logic die, flap_pend, go_q, rise, scan, last, hit_top, hit_floor;

  assign rise = go & ~go_q;
  assign scan = state inside {INIT_DRAW, ERASE, DRAW, R_ERASE};
  assign last = pix == LAST;
  assign v_inc = vel + G_S;
  assign v_nxt = flap_pend ? -FV_S : (v_inc > VM_S ? VM_S : v_inc);
  assign y_nxt = $signed({2'b00, y}) + v_nxt;
  assign hit_top = y_nxt <= YMIN_S;
  assign hit_floor = !hit_top && y_nxt >= YMAX_S;

  always_ff @(posedge clock) begin
    if (reset) state <= INIT_DRAW;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT_DRAW: state_n = last ? READY : INIT_DRAW;
      READY:     state_n = rise ? WAIT : READY;
      WAIT:      state_n = tick ? ERASE : WAIT;
      ERASE:     state_n = last ? UPDATE : ERASE;
      UPDATE:    state_n = DRAW;
      DRAW:      state_n = last ? (die ? DEAD : WAIT) : DRAW;
      DEAD:      state_n = rise ? R_ERASE : DEAD;
      R_ERASE:   state_n = last ? INIT_DRAW : R_ERASE;
      default:   state_n = INIT_DRAW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix <= '0;
      y <= Y0;
      vel <= '0;
      die <= 1'b0;
      flap_pend <= 1'b0;
      go_q <= 1'b0;
    end else begin
      go_q <= go;
      pix <= (scan && !last) ? pix + PW'(1) : '0;
      if (state == UPDATE) begin
        vel <= hit_top ? '0 : v_nxt;
        y <= hit_top ? YMIN8 : hit_floor ? YMAX8 : y_nxt[7:0];
        die <= hit_floor;
        flap_pend <= 1'b0;
      end else if (state == R_ERASE && last) begin
        y <= Y0;
        vel <= '0;
        die <= 1'b0;
        flap_pend <= 1'b0;
      end else if (rise && !(state inside {INIT_DRAW, R_ERASE})) begin
        flap_pend <= 1'b1;
      end
    end
  end

  // reset forces the idle pixel outputs combinationally so the reset cycle itself is clean
  always_comb begin
    plot = ~reset & scan;
    colour = (!reset && state inside {INIT_DRAW, DRAW}) ? BIRD_COL : BG_COL;
    out_x = reset ? X0 : X0 + 8'(pix % WP);
    out_y = reset ? Y0 : y + 8'(pix / WP);
    busy = state inside {INIT_DRAW, ERASE, UPDATE, DRAW, R_ERASE};
    dead = ~reset & (state == DEAD);
    y_pos = y;
  end
endmodule

// File: tb/tb_bird_sprite_engine.sv
// tb_bird_sprite_engine: table-driven and randomized checks against a frame-level physics model
module tb_bird_sprite_engine;
  logic clock = 1'b0, reset = 1'b1, go = 1'b0, tick = 1'b0;
  logic [2:0] colour;
  logic [7:0] out_x, out_y, y_pos;
  logic plot, busy, dead;

  int vecs = 0, errs = 0, cycles = 0;
  int my = 48, mv = 0;
  bit mdead = 0, pend = 0, g_last = 0;

  typedef struct {int fl; int y; bit d;} vec_t;
  vec_t tbl[34];

  bird_sprite_engine dut (
    .clock(clock), .reset(reset), .go(go), .tick(tick), .colour(colour), .out_x(out_x),
    .out_y(out_y), .plot(plot), .busy(busy), .dead(dead), .y_pos(y_pos)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    if (go && !g_last) pend = 1;
    g_last = go;
    #1;
    cycles++;
  endtask

  task automatic phys();
    int v, ny;
    v = pend ? -6 : (mv + 1 > 6 ? 6 : mv + 1);
    ny = my + v;
    if (ny <= 12) begin my = 12; mv = 0; end
    else if (ny >= 111) begin my = 111; mv = v; mdead = 1; end
    else begin my = ny; mv = v; end
    pend = 0;
  endtask

  task automatic scan(string nm, int yb, logic [2:0] col, bit rnd);
    for (int p = 0; p < 16; p++) begin
      check(nm, {plot, colour, out_x, out_y}, {1'b1, col, 8'(24 + p % 4), 8'(yb + p / 4)});
      if (rnd) begin
        tick = 1'($urandom_range(0, 1));
        go = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1; go = 0; tick = 0;
    cyc();
    check("reset_out", {plot, colour, out_x, out_y, dead}, {1'b0, 3'd0, 8'd24, 8'd48, 1'b0});
    check("reset_y", y_pos, 48);
    reset = 0; g_last = 0; pend = 0; my = 48; mv = 0; mdead = 0;
    #1;
  endtask

  task automatic init_to_ready();
    scan("init", 48, 3'b110, 0);
    check("ready", {plot, busy, dead, y_pos}, {3'b000, 8'd48});
  endtask

  task automatic leave_ready();
    go = 1; cyc(); go = 0;
  endtask

  task automatic frame(bit rnd);
    int t0, oy;
    t0 = cycles;
    tick = 1; cyc(); tick = 0;
    oy = my;
    scan("erase", oy, 3'b000, rnd);
    tick = 0; go = 0;
    check("update", {plot, busy}, 2'b01);
    phys();
    cyc();
    scan("draw", my, 3'b110, rnd);
    tick = 0; go = 0;
    check("frame_len", cycles - t0, 34);
    check("frame_y", y_pos, my);
    check("frame_dead", dead, mdead);
    check("frame_idle", {plot, busy}, 2'b00);
  endtask

  task automatic restart();
    for (int i = 0; i < 5; i++) begin
      tick = 1; cyc();
      check("dead_hold", {plot, dead, y_pos}, {2'b01, 8'd111});
    end
    tick = 0;
    go = 1; cyc(); go = 0;
    scan("r_erase", 111, 3'b000, 0);
    my = 48; mv = 0; mdead = 0; pend = 0;
    init_to_ready();
  endtask

  initial begin
    tbl = '{'{0, 42, 0}, '{0, 37, 0}, '{0, 33, 0}, '{0, 30, 0}, '{0, 28, 0}, '{0, 27, 0},
            '{0, 27, 0}, '{0, 28, 0}, '{0, 30, 0}, '{0, 33, 0}, '{1, 27, 0}, '{2, 21, 0},
            '{1, 15, 0}, '{2, 12, 0}, '{1, 12, 0}, '{0, 13, 0}, '{0, 15, 0}, '{0, 18, 0},
            '{0, 22, 0}, '{0, 27, 0}, '{0, 33, 0}, '{0, 39, 0}, '{0, 45, 0}, '{0, 51, 0},
            '{0, 57, 0}, '{0, 63, 0}, '{0, 69, 0}, '{0, 75, 0}, '{0, 81, 0}, '{0, 87, 0},
            '{0, 93, 0}, '{0, 99, 0}, '{0, 105, 0}, '{0, 111, 1}};
    do_reset();
    init_to_ready();
    leave_ready();
    for (int i = 0; i < 34; i++) begin
      if (tbl[i].fl == 1) begin go = 1; cyc(); go = 0; end
      else if (tbl[i].fl == 2) go = 1;
      frame(0);
      check("tbl_y", y_pos, tbl[i].y);
      check("tbl_dead", dead, tbl[i].d);
    end
    restart();
    leave_ready();
    for (int f = 0; f < 40; f++) begin
      if (mdead) begin restart(); leave_ready(); end
      for (int k = $urandom_range(0, 3); k > 0; k--) cyc();
      case ($urandom_range(0, 2))
        1: begin go = 1; cyc(); go = 0; end
        2: go = 1;
        default: ;
      endcase
      frame(1);
    end
    if (mdead) begin restart(); leave_ready(); end
    tick = 1; cyc(); tick = 0;
    scan("pre_rst_erase", my, 3'b000, 0);
    cyc();
    for (int i = 0; i < 5; i++) cyc();
    check("mid_draw", plot, 1'b1);
    reset = 1; cyc();
    check("rst_mid_draw", {plot, dead, y_pos}, {2'b00, 8'd48});
    reset = 0; g_last = 0; pend = 0; my = 48; mv = 0; mdead = 0;
    #1;
    init_to_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
